serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing diff = a - b. Built around the team's existing single-bit full_subtractor cell plus a registered borrow flop. It sits directly downstream of full_subtractor: it consumes the cell's diff/borrow outputs once per clock and assembles the multi-bit result. It trades WIDTH cycles of latency for a single subtractor cell, and exposes a start/busy/done handshake to the surrounding datapath.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ bin;
    assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one full_subtractor cell.
// Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             bflop;
    logic [CW-1:0]    count;
    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .bin    (bflop),
        .diff   (cell_diff),
        .borrow (cell_borrow)
    );

    // Only WIDTH-1 partial bits need storing; the final cell bit completes the word.
    assign res_next = {cell_diff, res_sr};

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bflop      <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bflop <= 1'b0;
                        count <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    bflop  <= cell_borrow;
                    res_sr <= res_next[WIDTH-1:1];
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        diff       <= res_next;
                        borrow_out <= cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (a_msb != b_msb) && (cell_diff != a_msb);
`endif
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver predicts results on a timeline, monitor checks them.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        bit           bo;
        bit           ov;
        int           de;
    } exp_t;

    exp_t q[$];
    bit   busy_exp[int];
    bit   rst_edges[int];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    bit   acc_valid = 0;
    int   acc_edge = 0;

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    // Drive inputs for the next edge and update the timeline model.
    task automatic drive(input bit s, input logic [W-1:0] av, input logic [W-1:0] bv, input bit r);
        int e;
        exp_t x;
        logic [W:0] wide;
        @(posedge clk);
        #2;
        e = edge_n + 1;
        rst = r;
        start = s;
        a = av;
        b = bv;
        if (r) begin
            rst_edges[e] = 1'b1;
            while (q.size() > 0 && q[$].de >= e) void'(q.pop_back());
            for (int i = e; i < e + W; i++) busy_exp.delete(i);
            acc_valid = 0;
        end else if (s && !(acc_valid && e >= acc_edge + 1 && e <= acc_edge + W)) begin
            wide = {1'b0, av} - {1'b0, bv};
            x.d  = wide[W-1:0];
            x.bo = (av < bv);
            x.ov = (av[W-1] != bv[W-1]) && (x.d[W-1] != av[W-1]);
            x.de = e + W;
            q.push_back(x);
            for (int i = e; i < e + W; i++) busy_exp[i] = 1'b1;
            acc_valid = 1;
            acc_edge = e;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, 1'b0);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every done.
    initial begin : monitor
        logic [W-1:0] hold_d;
        bit           hold_bo;
        bit           hold_ov;
        bit           exp_done;
        bit           exp_busy;
        exp_t         x;
        hold_d = '0;
        hold_bo = 0;
        hold_ov = 0;
        forever begin
            @(negedge clk);
            exp_done = (q.size() > 0) && (q[0].de == edge_n);
            exp_busy = busy_exp.exists(edge_n);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done: got %b expected %b (edge %0d)", done, exp_done, edge_n);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy: got %b expected %b (edge %0d)", busy, exp_busy, edge_n);
            end
            if (rst_edges.exists(edge_n)) begin
                hold_d = '0;
                hold_bo = 0;
                hold_ov = 0;
            end else if (exp_done) begin
                x = q.pop_front();
                hold_d = x.d;
                hold_bo = x.bo;
                hold_ov = x.ov;
            end
            checks++;
            if (diff !== hold_d || borrow_out !== hold_bo) begin
                errors++;
                $display("FAIL result: got diff=%h borrow=%b expected diff=%h borrow=%b (edge %0d)",
                         diff, borrow_out, hold_d, hold_bo, edge_n);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ovf !== hold_ov) begin
                errors++;
                $display("FAIL ovf: got %b expected %b (edge %0d)", ovf, hold_ov, edge_n);
            end
`endif
        end
    end

    initial begin : stimulus
        int drain;
        rst_edges[1] = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b0);

        drive(1'b1, 8'h05, 8'h03, 1'b0); idle(10);
        drive(1'b1, 8'h03, 8'h05, 1'b0); idle(10);
        drive(1'b1, 8'h00, 8'h00, 1'b0); idle(10);
        drive(1'b1, 8'hFF, 8'hFF, 1'b0); idle(10);
        drive(1'b1, 8'h80, 8'h01, 1'b0); idle(10);
        drive(1'b1, 8'h7F, 8'h01, 1'b0); idle(10);

        drive(1'b1, 8'h10, 8'h01, 1'b0); idle(2);
        drive(1'b1, 8'hAA, 8'h55, 1'b0); idle(8);

        drive(1'b1, 8'h20, 8'h01, 1'b0); idle(3);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        drive(1'b1, 8'h09, 8'h04, 1'b0); idle(10);

        for (int i = 0; i < 9; i++) drive(1'b1, 8'h09, 8'h04, 1'b0);
        drive(1'b1, 8'h01, 8'h02, 1'b0);
        idle(10);

        for (int i = 0; i < 2500; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 13 == 0) begin
                ra = '1;
                rb = '0;
            end
            drive($urandom_range(0, 3) == 0, ra, rb, $urandom_range(0, 79) == 0);
        end

        drain = 0;
        while (q.size() > 0 && drain < 40) begin
            drive(1'b0, '0, '0, 1'b0);
            drain++;
        end
        idle(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
